// File: rtl/counter_sequencer_pkg.sv
// Shared types and sizing for the counter sequencer.
// Imported by the interface, the counter and the sequencer top.
package counter_seq_pkg;

  localparam int COUNT_W    = 4;
  localparam int STEP_W_DEF = 8;
  localparam int RATE_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE
  } state_e;

endpackage

// File: rtl/counter_sequencer_if.sv
// Move-command handshake between the host and the sequencer.
// The host drives the master side; the sequencer takes the slave side.
interface counter_sequencer_if
  import counter_seq_pkg::*;
#(
  parameter int STEP_W = STEP_W_DEF,
  parameter int RATE_W = RATE_W_DEF
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_up;
  logic [STEP_W-1:0] cmd_steps;
  logic [RATE_W-1:0] cmd_rate;

  modport master (
    output cmd_valid,
    output cmd_up,
    output cmd_steps,
    output cmd_rate,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_up,
    input  cmd_steps,
    input  cmd_rate,
    output cmd_ready
  );

endinterface

// File: rtl/counter_sequencer_counter.sv
// Modulo-16 up/down counter with enable and async active-high reset.
// wrap flags the enabled cycle whose step crosses the 15/0 boundary.
module counter_sequencer_counter
  import counter_seq_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               up_down,
  output logic [COUNT_W-1:0] count,
  output logic               wrap
);

  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  logic [COUNT_W-1:0] count_q;
  logic [COUNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    wrap    = 1'b0;
    if (enable) begin
      if (up_down) begin
        count_d = count_q + COUNT_W'(1);
        wrap    = (count_q == CNT_MAX);
      end else begin
        count_d = count_q - COUNT_W'(1);
        wrap    = (count_q == '0);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/counter_sequencer.sv
// Runs one move command at a time: paces counter steps by the
// latched rate, honours pause/abort, and pulses done on termination.
module counter_sequencer
  import counter_seq_pkg::*;
#(
  parameter int STEP_W = STEP_W_DEF,
  parameter int RATE_W = RATE_W_DEF
)(
  input  logic               clk,
  input  logic               reset_n,
  counter_sequencer_if.slave cmd,
  input  logic               pause,
  input  logic               abort,
  output logic [COUNT_W-1:0] count,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic               wrap
);

  state_e            state_q, state_d;
  logic              dir_q, dir_d;
  logic [RATE_W-1:0] rate_q, rate_d;
  logic [RATE_W-1:0] presc_q, presc_d;
  logic [STEP_W-1:0] remaining_q, remaining_d;
  logic              aborted_q, aborted_d;

  logic step;
  logic last_step;

  assign last_step = step && (remaining_q == STEP_W'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (cmd.cmd_valid) begin
          state_d = (cmd.cmd_steps == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = DONE;
        end else if (last_step) begin
          state_d = DONE;
        end else if (pause) begin
          state_d = PAUSE;
        end
      end
      PAUSE: begin
        if (abort) begin
          state_d = DONE;
        end else if (!pause) begin
          state_d = RUN;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd.cmd_ready = (state_q == IDLE);
    busy          = (state_q == RUN) || (state_q == PAUSE);
    done          = (state_q == DONE);
    aborted       = (state_q == DONE) && aborted_q;
    // abort wins over a step falling due in the same cycle
    step          = (state_q == RUN) && !abort
                    && (presc_q == rate_q);
  end

  always_comb begin
    dir_d       = dir_q;
    rate_d      = rate_q;
    presc_d     = presc_q;
    remaining_d = remaining_q;
    aborted_d   = aborted_q;
    unique case (state_q)
      IDLE: begin
        if (cmd.cmd_valid) begin
          dir_d       = cmd.cmd_up;
          rate_d      = cmd.cmd_rate;
          remaining_d = cmd.cmd_steps;
          presc_d     = '0;
          aborted_d   = 1'b0;
        end
      end
      RUN: begin
        if (abort) begin
          aborted_d = 1'b1;
        end else if (step) begin
          presc_d     = '0;
          remaining_d = remaining_q - STEP_W'(1);
        end else begin
          presc_d = presc_q + RATE_W'(1);
        end
      end
      PAUSE: begin
        if (abort) begin
          aborted_d = 1'b1;
        end
      end
      DONE:    aborted_d = 1'b0;
      default: aborted_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dir_q       <= 1'b0;
      rate_q      <= '0;
      presc_q     <= '0;
      remaining_q <= '0;
      aborted_q   <= 1'b0;
    end else begin
      dir_q       <= dir_d;
      rate_q      <= rate_d;
      presc_q     <= presc_d;
      remaining_q <= remaining_d;
      aborted_q   <= aborted_d;
    end
  end

  counter_sequencer_counter u_counter (
    .clk     (clk),
    .reset   (~reset_n),
    .enable  (step),
    .up_down (dir_q),
    .count   (count),
    .wrap    (wrap)
  );

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed checks of command sequencing, pacing, pause, abort, reset.
// Inputs change at negedge; outputs are sampled 1 time unit later.
module tb_counter_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       pause;
  logic       abort;
  logic [3:0] count;
  logic       busy;
  logic       done;
  logic       aborted;
  logic       wrap;

  int checks   = 0;
  int failures = 0;

  counter_sequencer_if #(.STEP_W(8), .RATE_W(4)) cmd_if ();

  counter_sequencer #(.STEP_W(8), .RATE_W(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .cmd     (cmd_if),
    .pause   (pause),
    .abort   (abort),
    .count   (count),
    .busy    (busy),
    .done    (done),
    .aborted (aborted),
    .wrap    (wrap)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog_timeout checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic drive_cmd(input logic up, input logic [7:0] steps,
                           input logic [3:0] rate);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_up    = up;
    cmd_if.cmd_steps = steps;
    cmd_if.cmd_rate  = rate;
  endtask

  task automatic test_reset();
    reset_n          = 1'b0;
    pause            = 1'b0;
    abort            = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_up    = 1'b0;
    cmd_if.cmd_steps = '0;
    cmd_if.cmd_rate  = '0;
    #1;
    checks++;
    if (count !== 4'd0) begin
      failures++;
      $display("FAIL reset_count got=%0d exp=0", count);
    end
    checks++;
    if (cmd_if.cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got=%b exp=1", cmd_if.cmd_ready);
    end
    checks++;
    if ({busy, done, aborted, wrap} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=0000",
               {busy, done, aborted, wrap});
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_up_rate0();
    logic [3:0] exp_cnt;
    @(negedge clk);
    drive_cmd(1'b1, 8'd5, 4'd0);
    #1;
    checks++;
    if (cmd_if.cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL up0_accept_ready got=%b exp=1", cmd_if.cmd_ready);
    end
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      cmd_if.cmd_valid = 1'b0;
      #1;
      exp_cnt = (k <= 6) ? 4'(k - 1) : 4'd5;
      checks++;
      if (count !== exp_cnt) begin
        failures++;
        $display("FAIL up0_count k=%0d got=%0d exp=%0d", k, count, exp_cnt);
      end
      checks++;
      if (cmd_if.cmd_ready !== 1'(k == 7)) begin
        failures++;
        $display("FAIL up0_ready k=%0d got=%b exp=%b",
                 k, cmd_if.cmd_ready, k == 7);
      end
      checks++;
      if (done !== 1'(k == 6)) begin
        failures++;
        $display("FAIL up0_done k=%0d got=%b exp=%b", k, done, k == 6);
      end
      checks++;
      if (busy !== 1'(k <= 5)) begin
        failures++;
        $display("FAIL up0_busy k=%0d got=%b exp=%b", k, busy, k <= 5);
      end
      if (k == 6) begin
        checks++;
        if (aborted !== 1'b0) begin
          failures++;
          $display("FAIL up0_aborted got=%b exp=0", aborted);
        end
      end
    end
  endtask

  task automatic test_down_rate2();
    logic [3:0] exp_cnt;
    @(negedge clk);
    drive_cmd(1'b0, 8'd7, 4'd2);
    for (int k = 1; k <= 23; k++) begin
      @(negedge clk);
      cmd_if.cmd_valid = 1'b0;
      #1;
      exp_cnt = 4'(5 - (k - 1) / 3);
      checks++;
      if (count !== exp_cnt) begin
        failures++;
        $display("FAIL dn2_count k=%0d got=%0d exp=%0d", k, count, exp_cnt);
      end
      checks++;
      if (wrap !== 1'(k == 18)) begin
        failures++;
        $display("FAIL dn2_wrap k=%0d got=%b exp=%b", k, wrap, k == 18);
      end
      checks++;
      if (done !== 1'(k == 22)) begin
        failures++;
        $display("FAIL dn2_done k=%0d got=%b exp=%b", k, done, k == 22);
      end
    end
  endtask

  task automatic test_pause();
    logic [3:0] exp_cnt;
    int n;
    @(negedge clk);
    drive_cmd(1'b1, 8'd10, 4'd1);
    for (int k = 1; k <= 28; k++) begin
      @(negedge clk);
      cmd_if.cmd_valid = 1'b0;
      pause = (k >= 5 && k <= 10);
      #1;
      n = int'(k > 2) + int'(k > 4) + ((k > 12) ? (k - 11) / 2 : 0);
      exp_cnt = 4'(14 + n);
      checks++;
      if (count !== exp_cnt) begin
        failures++;
        $display("FAIL pause_count k=%0d got=%0d exp=%0d", k, count, exp_cnt);
      end
      checks++;
      if (wrap !== 1'(k == 4)) begin
        failures++;
        $display("FAIL pause_wrap k=%0d got=%b exp=%b", k, wrap, k == 4);
      end
      checks++;
      if (busy !== 1'(k <= 26)) begin
        failures++;
        $display("FAIL pause_busy k=%0d got=%b exp=%b", k, busy, k <= 26);
      end
      checks++;
      if (done !== 1'(k == 27)) begin
        failures++;
        $display("FAIL pause_done k=%0d got=%b exp=%b", k, done, k == 27);
      end
    end
    pause = 1'b0;
  endtask

  task automatic test_abort();
    logic [3:0] exp_cnt;
    @(negedge clk);
    drive_cmd(1'b1, 8'd20, 4'd0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      cmd_if.cmd_valid = 1'b0;
      abort = (k == 4);
      #1;
      exp_cnt = (k <= 4) ? 4'(8 + k - 1) : 4'd11;
      checks++;
      if (count !== exp_cnt) begin
        failures++;
        $display("FAIL abort_count k=%0d got=%0d exp=%0d", k, count, exp_cnt);
      end
      checks++;
      if (done !== 1'(k == 5) || aborted !== 1'(k == 5)) begin
        failures++;
        $display("FAIL abort_done k=%0d got=%b%b exp=%b%b",
                 k, done, aborted, k == 5, k == 5);
      end
      checks++;
      if (cmd_if.cmd_ready !== 1'(k == 6)) begin
        failures++;
        $display("FAIL abort_ready k=%0d got=%b exp=%b",
                 k, cmd_if.cmd_ready, k == 6);
      end
      checks++;
      if (busy !== 1'(k <= 4)) begin
        failures++;
        $display("FAIL abort_busy k=%0d got=%b exp=%b", k, busy, k <= 4);
      end
    end
    drive_cmd(1'b1, 8'd1, 4'd0);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b1 || count !== 4'd11) begin
      failures++;
      $display("FAIL abort_next_run got=%b/%0d exp=1/11", busy, count);
    end
    @(negedge clk);
    #1;
    checks++;
    if (done !== 1'b1 || aborted !== 1'b0 || count !== 4'd12) begin
      failures++;
      $display("FAIL abort_next_done got=%b%b/%0d exp=10/12",
               done, aborted, count);
    end
  endtask

  task automatic test_zero_steps();
    @(negedge clk);
    drive_cmd(1'b1, 8'd0, 4'd3);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    #1;
    checks++;
    if ({done, aborted, busy, cmd_if.cmd_ready} !== 4'b1000) begin
      failures++;
      $display("FAIL zero_done got=%b exp=1000",
               {done, aborted, busy, cmd_if.cmd_ready});
    end
    checks++;
    if (count !== 4'd12) begin
      failures++;
      $display("FAIL zero_count got=%0d exp=12", count);
    end
    @(negedge clk);
    #1;
    checks++;
    if (cmd_if.cmd_ready !== 1'b1 || done !== 1'b0 || count !== 4'd12) begin
      failures++;
      $display("FAIL zero_idle got=%b%b/%0d exp=10/12",
               cmd_if.cmd_ready, done, count);
    end
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    drive_cmd(1'b1, 8'd20, 4'd0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      cmd_if.cmd_valid = 1'b0;
      #1;
      checks++;
      if (count !== 4'(12 + k - 1)) begin
        failures++;
        $display("FAIL rstmid_count k=%0d got=%0d exp=%0d",
                 k, count, 12 + k - 1);
      end
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (count !== 4'd0) begin
      failures++;
      $display("FAIL rstmid_async_count got=%0d exp=0", count);
    end
    checks++;
    if ({busy, done, aborted, wrap, cmd_if.cmd_ready} !== 5'b00001) begin
      failures++;
      $display("FAIL rstmid_async_flags got=%b exp=00001",
               {busy, done, aborted, wrap, cmd_if.cmd_ready});
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      #1;
      checks++;
      if (cmd_if.cmd_ready !== 1'b1 || busy !== 1'b0 || count !== 4'd0) begin
        failures++;
        $display("FAIL rstmid_idle k=%0d got=%b%b/%0d exp=10/0",
                 k, cmd_if.cmd_ready, busy, count);
      end
    end
  endtask

  initial begin
    test_reset();
    test_up_rate0();
    test_down_rate2();
    test_pause();
    test_abort();
    test_zero_steps();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
